dual_mode_buffer: RTL
=====================

Name: dual_mode_buffer

Overview:
Parametrised storage buffer that operates as a LIFO (stack) or a FIFO (queue), selectable per cycle by a mode input.
Storage is a circular array addressed by a head pointer and an occupancy count, so the two modes share storage and may be mixed while the buffer holds data.
It adds occupancy count and almost-full outputs, plus optional error flags.
It serves as the drop-in next generation of the team's LIFO buffers for datapaths that need both orderings.

Parameters:
DATA_W, 16, data word width in bits
LIFO_SIZE, 6, log2 of depth; DEPTH = 2**LIFO_SIZE entries
AFULL_THR, 60, almost_full asserts when count >= AFULL_THR; legal range 1..DEPTH

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
write  input  1  push request
read  input  1  pop request
mode  input  1  0 = LIFO, 1 = FIFO; sampled every cycle
data_in  input  DATA_W  push data
data_out  output  DATA_W  current head entry (show-ahead, combinational from storage)
val  output  1  buffer non-empty; data_out valid
full  output  1  count == DEPTH
almost_full  output  1  count >= AFULL_THR
count  output  LIFO_SIZE+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (async, active-high): head pointer hp=0 and count=0.
  - Outputs: val=0, full=0, almost_full=0, count=0.
  - data_out is don't-care; storage contents are not cleared.
- Pointer arithmetic: all index arithmetic is modulo DEPTH, LIFO_SIZE bits, with natural wrap.
- data_out = mem[hp]. It changes in the same cycle as a push/pop commit, i.e. it is visible after the clock edge. Zero-cycle read latency.
- Accept rules, evaluated on each rising edge:
  - push_ok = write & (~full | read) & ~(read & ~val & 0)
  - Simplified: push_ok = write & (~full | (read & val)).
  - pop_ok = read & val.
- Write only, push_ok:
  - LIFO: mem[hp-1] <= data_in, hp <= hp-1.
  - FIFO: mem[hp+count] <= data_in, hp unchanged.
  - Both modes: count+1.
- Read only, pop_ok: hp <= hp+1, count-1. Identical in both modes.
- Write and read, buffer non-empty:
  - LIFO: mem[hp] <= data_in (top replaced), hp unchanged.
  - FIFO: mem[hp+count] <= data_in, hp <= hp+1.
  - count unchanged. Legal when full; in FIFO mode when full, the write slot equals the freed head slot.
- Write and read, buffer empty: read ignored; push as write-only. count becomes 1, data_out = data_in next cycle.
- Write when full without read: dropped, no state change.
- Read when empty: ignored, no state change.
- Mode change while non-empty is legal and affects only where subsequent pushes land. Pops always take the head.
- full, almost_full, val and count are registered-state derived: combinational from count, no extra latency.
- Reset mid-operation: immediate async clear of hp/count; any in-flight push on that edge is lost.

Optional Feature:
Macro DUAL_MODE_BUFFER_ERR_FLAGS_EN.
- Defined: adds ports err_clr (input, 1), overflow (output, 1) and underflow (output, 1).
  - overflow sets on any cycle with write & full & ~read.
  - underflow sets on any cycle with read & ~val & ~write.
  - Both flags are sticky until err_clr=1, which clears them on the next edge. A set event in the same cycle as err_clr wins.
  - Both reset to 0.
- Undefined: ports absent; dropped and ignored requests are silent.

Decomposition:
- Package dual_mode_buffer_pkg:
  - mode encodings MODE_LIFO=1'b0 and MODE_FIFO=1'b1.
  - helper function for depth from LIFO_SIZE.
- One sub-module, dual_mode_buffer_mem:
  - DEPTH x DATA_W register array.
  - One synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr -> rdata).
  - No reset on the array.
- Top-level holds hp, count, accept logic and flags.

Test Plan:
- LIFO order: mode=0, push 0x0001, 0x0002, 0x0003, then pop x3 -> data_out reads 0x0003, 0x0002, 0x0001; val=0 and count=0 after the third pop.
- FIFO order with wrap: mode=1, push 64 words 0x0000..0x003F -> full=1 and count=64. Then pop 10 and push 10 (0x0100..0x0109), then drain -> output sequence 0x000A..0x003F followed by 0x0100..0x0109.
- Full boundary: push 64 words, then write-only 0xDEAD -> count stays 64 and the write is dropped. Then write+read in LIFO with 0xBEEF -> data_out=0xBEEF and count=64.
- Empty boundary: read-only on empty -> no change. Then write+read with 0x1234 on empty -> count=1, data_out=0x1234.
- Mixed mode: in FIFO push 0xA, 0xB; in LIFO push 0xC -> pops yield 0xC, 0xA, 0xB. almost_full toggles exactly at count 59->60 with the default threshold.
- Async reset mid-stream with 5 entries -> val, full, almost_full and count drop to 0 without a clock edge. With DUAL_MODE_BUFFER_ERR_FLAGS_EN: overflow/underflow set by the dropped requests, hold, and clear on err_clr.

Source files
------------

// File: rtl/dual_mode_buffer_pkg.sv
// Shared definitions for the dual-mode (LIFO/FIFO) buffer: mode encodings and
// the depth helper used to size storage and occupancy.
package dual_mode_buffer_pkg;

  localparam logic MODE_LIFO = 1'b0;
  localparam logic MODE_FIFO = 1'b1;

  function automatic int depth_of(input int lifo_size);
    return 1 << lifo_size;
  endfunction

endpackage

// File: rtl/dual_mode_buffer_mem.sv
// Register-array storage for the dual-mode buffer: one synchronous write port
// and one asynchronous read port. The array is deliberately not reset.
module dual_mode_buffer_mem
  import dual_mode_buffer_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int LIFO_SIZE = 6
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [LIFO_SIZE-1:0] waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic [LIFO_SIZE-1:0] raddr,
  output logic [DATA_W-1:0]    rdata
);

  localparam int DEPTH = depth_of(LIFO_SIZE);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dual_mode_buffer.sv
// Circular-array buffer acting as a stack or a queue per cycle (mode input).
// Optional sticky overflow/underflow flags under DUAL_MODE_BUFFER_ERR_FLAGS_EN.
module dual_mode_buffer
  import dual_mode_buffer_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int LIFO_SIZE = 6,
  parameter int AFULL_THR = 60
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write,
  input  logic                 read,
  input  logic                 mode,
  input  logic [DATA_W-1:0]    data_in,
  output logic [DATA_W-1:0]    data_out,
  output logic                 val,
  output logic                 full,
  output logic                 almost_full,
  output logic [LIFO_SIZE:0]   count
`ifdef DUAL_MODE_BUFFER_ERR_FLAGS_EN
  ,
  input  logic                 err_clr,
  output logic                 overflow,
  output logic                 underflow
`endif
);

  localparam int                 DEPTH   = depth_of(LIFO_SIZE);
  localparam logic [LIFO_SIZE:0] DEPTH_C = (LIFO_SIZE+1)'(DEPTH);
  localparam logic [LIFO_SIZE:0] AFULL_C = (LIFO_SIZE+1)'(AFULL_THR);

  logic [LIFO_SIZE-1:0] hp_q, hp_d;
  logic [LIFO_SIZE:0]   count_q, count_d;
  logic [LIFO_SIZE-1:0] tail;
  logic [LIFO_SIZE-1:0] waddr;
  logic                 we;
  logic                 push_ok;
  logic                 pop_ok;

  assign val         = (count_q != '0);
  assign full        = (count_q == DEPTH_C);
  assign almost_full = (count_q >= AFULL_C);
  assign count       = count_q;

  // A full buffer has count low bits of zero, so tail aliases the head slot.
  assign tail    = hp_q + count_q[LIFO_SIZE-1:0];
  assign push_ok = write & (~full | (read & val));
  assign pop_ok  = read & val;

  always_comb begin
    hp_d    = hp_q;
    count_d = count_q;
    we      = 1'b0;
    waddr   = tail;
    if (push_ok && pop_ok) begin
      we = 1'b1;
      case (mode)
        MODE_LIFO: waddr = hp_q;
        MODE_FIFO: hp_d  = hp_q + 1'b1;
        default:   ;
      endcase
    end else if (push_ok) begin
      we      = 1'b1;
      count_d = count_q + 1'b1;
      case (mode)
        MODE_LIFO: begin
          waddr = hp_q - 1'b1;
          hp_d  = hp_q - 1'b1;
        end
        MODE_FIFO: waddr = tail;
        default:   ;
      endcase
    end else if (pop_ok) begin
      hp_d    = hp_q + 1'b1;
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hp_q    <= '0;
      count_q <= '0;
    end else begin
      hp_q    <= hp_d;
      count_q <= count_d;
    end
  end

  dual_mode_buffer_mem #(
    .DATA_W    (DATA_W),
    .LIFO_SIZE (LIFO_SIZE)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (data_in),
    .raddr (hp_q),
    .rdata (data_out)
  );

`ifdef DUAL_MODE_BUFFER_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // A set event in the same cycle as err_clr takes priority.
  always_comb begin
    overflow_d  = err_clr ? 1'b0 : overflow_q;
    underflow_d = err_clr ? 1'b0 : underflow_q;
    if (write && full && !read) overflow_d = 1'b1;
    if (read && !val && !write) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule
